// File: rtl/mem_pkg.sv
// Shared constants and opcode decode for the memory access sequencer.
// State codes are plain 3-bit constants so the encoding is stable for external checkers.
package mem_pkg;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_LH = 6'b100001;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_SB = 6'b101000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_MERGE = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam int ACK_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } op_size_e;

  typedef struct packed {
    logic     legal;
    logic     store;
    op_size_e size;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [5:0] opc);
    op_info_t info;
    info = '{legal: 1'b1, store: 1'b0, size: SZ_WORD};
    case (opc)
      OP_LW: info.size = SZ_WORD;
      OP_SW: info.store = 1'b1;
      OP_LH: info.size = SZ_HALF;
      OP_SH: begin
        info.store = 1'b1;
        info.size  = SZ_HALF;
      end
      OP_LB: info.size = SZ_BYTE;
      OP_SB: begin
        info.store = 1'b1;
        info.size  = SZ_BYTE;
      end
      default: info.legal = 1'b0;
    endcase
    return info;
  endfunction

  function automatic logic misaligned(input op_info_t info, input logic [1:0] low);
    logic bad;
    case (info.size)
      SZ_WORD: bad = (low != 2'b00);
      SZ_HALF: bad = low[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mas_timer.sv
// Ack-wait counter: counts enabled cycles, flags the last allowed cycle.
// A clear wins over enable so each new access phase starts from zero.
module mas_timer #(
  parameter int LIMIT = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       enable,
  output logic [4:0] count,
  output logic       expired
);

  localparam logic [4:0] LAST = 5'(LIMIT - 1);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count <= 5'd0;
    end else if (clear) begin
      count <= 5'd0;
    end else if (enable) begin
      count <= count + 5'd1;
    end
  end

  // Asserted during the LIMIT-th waiting cycle, so the phase lasts exactly LIMIT cycles.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences execute-stage load/store requests onto a word-wide data memory,
// using an external merge unit for sub-word reads and read-modify-write stores.
module mem_access_sequencer
  import mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_rt,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] dec_memout,
  output logic [31:0] dec_rt,
  output logic [5:0]  dec_opcode,
  output logic [1:0]  dec_op,
  input  logic [31:0] dec_result,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        stall,
  output logic [2:0]  dbg_state,
  output logic [4:0]  dbg_count
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_valid is ignored whenever req_ready is low, and stall reports that case.

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic        ready_en;
  logic        set_err;
  logic        err_q;
  logic [5:0]  lat_opcode;
  logic [31:0] lat_addr;
  logic [31:0] lat_rt;
  op_info_t    lat_info;
  logic [31:0] rdata_q;
  logic [31:0] merged_q;

  op_info_t    req_info;
  logic        req_bad;
  logic        accept;

  logic        tmr_clear;
  logic        tmr_en;
  logic        tmr_expired;
  logic [4:0]  tmr_count;

  assign req_info = decode_op(req_opcode);
  assign req_bad  = !req_info.legal || misaligned(req_info, req_addr[1:0]);
  assign accept   = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_bad) begin
            state_nxt = ST_RESP;
            set_err   = 1'b1;
          end else if (req_info.store && (req_info.size == SZ_WORD)) begin
            state_nxt = ST_WRITE;
          end else begin
            state_nxt = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (mem_ack) begin
          state_nxt = (lat_info.size == SZ_WORD) ? ST_RESP : ST_MERGE;
        end else if (tmr_expired) begin
          state_nxt = ST_RESP;
          set_err   = 1'b1;
        end
      end
      ST_MERGE: begin
        state_nxt = lat_info.store ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        if (mem_ack) begin
          state_nxt = ST_RESP;
        end else if (tmr_expired) begin
          state_nxt = ST_RESP;
          set_err   = 1'b1;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign tmr_en    = (state == ST_READ) || (state == ST_WRITE);
  assign tmr_clear = (state_nxt != state);

  mas_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      ready_en   <= 1'b0;
      err_q      <= 1'b0;
      lat_opcode <= 6'd0;
      lat_addr   <= 32'd0;
      lat_rt     <= 32'd0;
      lat_info   <= '0;
      rdata_q    <= 32'd0;
      merged_q   <= 32'd0;
    end else begin
      // ready_en keeps req_ready low through reset and for the release edge itself.
      ready_en <= 1'b1;
      state    <= state_nxt;
      if (accept) begin
        lat_opcode <= req_opcode;
        lat_addr   <= req_addr;
        lat_rt     <= req_rt;
        lat_info   <= req_info;
        err_q      <= set_err;
      end else if (set_err) begin
        err_q <= 1'b1;
      end
      if ((state == ST_READ) && mem_ack) begin
        rdata_q <= mem_rdata;
      end
      if (state == ST_MERGE) begin
        merged_q <= dec_result;
      end
    end
  end

  // Memory-side outputs are decoded from state so a reset drops them at once.
  assign req_ready = ready_en && (state == ST_IDLE);
  assign mem_en    = (state == ST_READ) || (state == ST_WRITE);
  assign mem_we    = (state == ST_WRITE);
  assign mem_addr  = mem_en ? {lat_addr[31:2], 2'b00} : 32'd0;
  assign mem_wdata = (state == ST_WRITE)
                     ? ((lat_info.size == SZ_WORD) ? lat_rt : merged_q)
                     : 32'd0;

  assign dec_memout = rdata_q;
  assign dec_rt     = lat_rt;
  assign dec_opcode = lat_opcode;
  assign dec_op     = lat_addr[1:0];

  always_comb begin
    rsp_data = 32'd0;
    if ((state == ST_RESP) && !err_q && !lat_info.store) begin
      rsp_data = (lat_info.size == SZ_WORD) ? rdata_q : merged_q;
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = (state == ST_RESP) && err_q;
  assign stall     = req_valid && !req_ready;
  assign dbg_state = state;
  assign dbg_count = tmr_count;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a behavioural sub-word merge unit.
module tb_mem_access_sequencer;
  import mem_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_rt;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] dec_memout;
  logic [31:0] dec_rt;
  logic [5:0]  dec_opcode;
  logic [1:0]  dec_op;
  logic [31:0] dec_result;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        stall;
  logic [2:0]  dbg_state;
  logic [4:0]  dbg_count;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  mem_access_sequencer #(.ACK_TIMEOUT(16)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_addr   (req_addr),
    .req_rt     (req_rt),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .dec_memout (dec_memout),
    .dec_rt     (dec_rt),
    .dec_opcode (dec_opcode),
    .dec_op     (dec_op),
    .dec_result (dec_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .stall      (stall),
    .dbg_state  (dbg_state),
    .dbg_count  (dbg_count)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Little-endian merge unit: loads sign-extend the addressed lane, stores replace it.
  always_comb begin
    logic [31:0] shifted;
    logic [31:0] bmask;
    logic [31:0] hmask;
    shifted    = dec_memout >> {dec_op, 3'b000};
    bmask      = 32'h0000_00FF << {dec_op, 3'b000};
    hmask      = 32'h0000_FFFF << {dec_op[1], 4'b0000};
    dec_result = dec_memout;
    case (dec_opcode)
      OP_LB: dec_result = {{24{shifted[7]}}, shifted[7:0]};
      OP_LH: begin
        shifted    = dec_memout >> {dec_op[1], 4'b0000};
        dec_result = {{16{shifted[15]}}, shifted[15:0]};
      end
      OP_SB: dec_result = (dec_memout & ~bmask) | ({24'd0, dec_rt[7:0]} << {dec_op, 3'b000});
      OP_SH: dec_result = (dec_memout & ~hmask) | ({16'd0, dec_rt[15:0]} << {dec_op[1], 4'b0000});
      default: dec_result = dec_memout;
    endcase
  end

  // driver tasks
  task automatic step();
    @(negedge Clk);
  endtask

  task automatic issue(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] rt);
    req_valid  = 1'b1;
    req_opcode = opc;
    req_addr   = addr;
    req_rt     = rt;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input string tag, input logic exp_err);
    logic [31:0] e;
    e = 32'hXXXX_XXXX;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, rsp_data, e);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    Reset      = 1'b0;
    req_valid  = 1'b0;
    req_opcode = 6'd0;
    req_addr   = 32'd0;
    req_rt     = 32'd0;
    mem_rdata  = 32'd0;
    mem_ack    = 1'b0;

    // reset state
    step();
    step();
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("rst_dec_rt", dec_rt, 32'd0);
    chk("rst_count", {27'd0, dbg_count}, 32'd0);
    Reset = 1'b1;
    step();
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // LW 0x100, zero wait states; ack already high in IDLE must be ignored
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    issue(OP_LW, 32'h0000_0100, 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    step();
    req_valid = 1'b0;
    chk("lw_en", {31'd0, mem_en}, 32'd1);
    chk("lw_we", {31'd0, mem_we}, 32'd0);
    chk("lw_addr", mem_addr, 32'h0000_0100);
    chk("lw_ready_busy", {31'd0, req_ready}, 32'd0);
    step();
    mem_ack = 1'b0;
    expect_rsp("lw_rsp", 1'b0);
    chk("lw_rsp_en", {31'd0, mem_en}, 32'd0);
    step();
    chk("lw_rsp_once", {31'd0, rsp_valid}, 32'd0);
    chk("lw_idle_ready", {31'd0, req_ready}, 32'd1);

    // SB 0x102 read-modify-write
    issue(OP_SB, 32'h0000_0102, 32'h0000_00AA);
    exp_q.push_back(32'd0);
    step();
    req_valid = 1'b0;
    chk("sb_rd_addr", mem_addr, 32'h0000_0100);
    chk("sb_rd_we", {31'd0, mem_we}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1122_3344;
    step();
    mem_ack = 1'b0;
    chk("sb_merge_en", {31'd0, mem_en}, 32'd0);
    chk("sb_memout", dec_memout, 32'h1122_3344);
    chk("sb_dec_op", {30'd0, dec_op}, 32'd2);
    step();
    chk("sb_wr_we", {31'd0, mem_we}, 32'd1);
    chk("sb_wr_en", {31'd0, mem_en}, 32'd1);
    chk("sb_wr_addr", mem_addr, 32'h0000_0100);
    chk("sb_wr_data", mem_wdata, 32'h11AA_3344);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    expect_rsp("sb_rsp", 1'b0);
    step();

    // LH misaligned
    issue(OP_LH, 32'h0000_0103, 32'd0);
    exp_q.push_back(32'd0);
    step();
    req_valid = 1'b0;
    expect_rsp("lh_mis", 1'b1);
    chk("lh_mis_en", {31'd0, mem_en}, 32'd0);
    step();

    // illegal opcode
    issue(6'b000000, 32'h0000_0100, 32'd0);
    exp_q.push_back(32'd0);
    step();
    req_valid = 1'b0;
    expect_rsp("illegal", 1'b1);
    chk("illegal_en", {31'd0, mem_en}, 32'd0);
    step();

    // SW with ack withheld: 16 write cycles then error
    issue(OP_SW, 32'h0000_0200, 32'h1234_5678);
    exp_q.push_back(32'd0);
    step();
    req_valid = 1'b0;
    chk("sw_wdata", mem_wdata, 32'h1234_5678);
    chk("sw_we", {31'd0, mem_we}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("sw_to_en", {31'd0, mem_en}, 32'd1);
      step();
    end
    expect_rsp("sw_to", 1'b1);
    chk("sw_to_en_drop", {31'd0, mem_en}, 32'd0);
    step();
    chk("sw_to_ready", {31'd0, req_ready}, 32'd1);

    // next request after timeout is accepted
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    issue(OP_LW, 32'h0000_0104, 32'd0);
    exp_q.push_back(32'h0BAD_F00D);
    step();
    req_valid = 1'b0;
    chk("lw2_addr", mem_addr, 32'h0000_0104);
    step();
    mem_ack = 1'b0;
    expect_rsp("lw2_rsp", 1'b0);
    step();

    // reset during an SH read
    issue(OP_SH, 32'h0000_0106, 32'h0000_5555);
    step();
    req_valid = 1'b0;
    chk("sh_rd_en", {31'd0, mem_en}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("sh_rst_en", {31'd0, mem_en}, 32'd0);
    chk("sh_rst_addr", mem_addr, 32'd0);
    chk("sh_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("sh_rst_dec_rt", dec_rt, 32'd0);
    chk("sh_rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    step();
    chk("sh_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    Reset = 1'b1;
    step();
    chk("sh_rel_ready", {31'd0, req_ready}, 32'd1);
    chk("sh_rel_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // LB with a second request held valid behind it
    issue(OP_LB, 32'h0000_0101, 32'd0);
    exp_q.push_back(32'hFFFF_FF80);
    step();
    issue(OP_LW, 32'h0000_0300, 32'd0);
    chk("lb_stall_rd", {31'd0, stall}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_8000;
    step();
    mem_ack = 1'b0;
    chk("lb_stall_merge", {31'd0, stall}, 32'd1);
    step();
    chk("lb_stall_resp", {31'd0, stall}, 32'd1);
    expect_rsp("lb_rsp", 1'b0);
    exp_q.push_back(32'hCAFE_F00D);
    step();
    chk("b2b_stall_idle", {31'd0, stall}, 32'd0);
    chk("b2b_ready", {31'd0, req_ready}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    step();
    req_valid = 1'b0;
    chk("b2b_addr", mem_addr, 32'h0000_0300);
    step();
    mem_ack = 1'b0;
    expect_rsp("b2b_rsp", 1'b0);
    step();

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
